// File: rtl/dds_step_controller.sv
// DDS tuning-word controller: six active-low buttons are synchronized, debounced and edge-detected; each accepted press applies one saturating step adjustment.
// Optional auto-repeat while a button is held: define DDS_STEP_AUTOREPEAT_EN.
module dds_step_controller #(
  parameter int STEP_W          = 23,
  parameter int STEP_MIN        = 10000,
  parameter int STEP_MAX        = 2000000,
  parameter int DELTA_COARSE    = 10000,
  parameter int DELTA_MICRO     = 1000,
  parameter int DELTA_NANO      = 1,
`ifdef DDS_STEP_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
`endif
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_add,
  input  logic              sw_sub,
  input  logic              sw_micro_add,
  input  logic              sw_micro_sub,
  input  logic              sw_nano_add,
  input  logic              sw_nano_sub,
  output logic [STEP_W-1:0] step,
  output logic              step_update,
  output logic              at_limit,
  output logic [1:0]        dbg_state
);

  localparam int AW  = STEP_W + 1;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0]  MIN_W    = AW'(STEP_MIN);
  localparam logic [AW-1:0]  MAX_W    = AW'(STEP_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;

  // Index 0 has the highest priority; even indices add, odd indices subtract.
  logic [5:0] raw;
  assign raw = {sw_nano_sub, sw_nano_add, sw_micro_sub, sw_micro_add, sw_sub, sw_add};

  logic [5:0]     sync1, sync2, deb, deb_prev, press;
  logic [DCW-1:0] dcnt [6];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '1;
      sync2    <= '1;
      deb      <= '1;
      deb_prev <= '1;
      press    <= '0;
      for (int i = 0; i < 6; i++) dcnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= deb_prev & ~deb;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx, pick_idx, adj_idx;
  logic       any_press, apply;
  logic [AW-1:0] delta_w, step_w, sum_w, new_w;

  always_comb begin
    pick_idx  = 3'd0;
    any_press = |press;
    for (int i = 5; i >= 0; i--) begin
      if (press[i]) pick_idx = 3'(i);
    end
  end

  assign adj_idx = (state == IDLE) ? pick_idx : idx;
  assign step_w  = {1'b0, step};
  assign sum_w   = step_w + delta_w;

  always_comb begin
    delta_w = AW'(DELTA_NANO);
    case (adj_idx[2:1])
      2'd0:    delta_w = AW'(DELTA_COARSE);
      2'd1:    delta_w = AW'(DELTA_MICRO);
      default: delta_w = AW'(DELTA_NANO);
    endcase
    if (!adj_idx[0]) new_w = (sum_w > MAX_W) ? MAX_W : sum_w;
    else             new_w = (step_w < MIN_W + delta_w) ? MIN_W : step_w - delta_w;
  end

`ifdef DDS_STEP_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);
  logic [RCW-1:0] rcnt, rcnt_nx;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    apply    = 1'b0;
    case (state)
      IDLE: begin
        if (any_press) begin
          apply    = 1'b1;
          idx_nx   = pick_idx;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (deb[idx]) state_nx = IDLE;
`ifdef DDS_STEP_AUTOREPEAT_EN
        else if (rcnt == RD_LAST) begin
          apply    = 1'b1;
          state_nx = REPEAT;
        end
`endif
      end
      REPEAT: begin
`ifdef DDS_STEP_AUTOREPEAT_EN
        if (deb[idx])              state_nx = IDLE;
        else if (rcnt == RP_LAST)  apply    = 1'b1;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
`ifdef DDS_STEP_AUTOREPEAT_EN
    // The counter restarts on every adjustment so it times both the delay and each period.
    rcnt_nx = (apply || state_nx == IDLE) ? '0 : rcnt + 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      step        <= STEP_W'(STEP_MIN);
      step_update <= 1'b0;
      at_limit    <= 1'b1;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      step_update <= apply && (new_w[STEP_W-1:0] != step);
      if (apply) begin
        step     <= new_w[STEP_W-1:0];
        at_limit <= (new_w == MIN_W) || (new_w == MAX_W);
      end
    end
  end

`ifdef DDS_STEP_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rcnt <= '0;
    else        rcnt <= rcnt_nx;
  end
`endif

  assign dbg_state = state;

endmodule
